// File: rtl/bldc_mul_arbiter.sv
// bldc_mul_arbiter: round-robin sequencer that shares one serial 16x16
// multiplier between N_REQ requesters. It latches the winner's operands,
// handshakes with the multiplier, then scales and saturates the product.
// A stalled multiplier is abandoned after TIMEOUT cycles.
// Optional build macro BLDC_MUL_ARB_PRIORITY0_EN: requester 0 gets fixed
// priority and the others rotate among themselves.
module bldc_mul_arbiter #(
  parameter int N_REQ   = 3,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   a_flat,
  input  logic [16*N_REQ-1:0]   b_flat,
  output logic [N_REQ-1:0]      done,
  output logic [OUT_W-1:0]      result,
  output logic                  busy,
  output logic                  sat,
  output logic                  err,
  output logic                  mul_load,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic                  mul_valid,
  input  logic [31:0]           mul_prod
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] RES_MAX = {{(32-OUT_W){1'b0}}, {OUT_W{1'b1}}};

`ifdef BLDC_MUL_ARB_PRIORITY0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   tcnt;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     pos;
  logic [31:0]        prod_shifted;
  logic               clamp;

  assign busy         = (state != IDLE);
  assign prod_shifted = mul_prod >> SHIFT;
  assign clamp        = (prod_shifted > RES_MAX);
  assign ptr_next     = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

  // Winner search: first set req bit at or above ptr, wrapping at N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    if (PRIO0 && req[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        pos = {1'b0, ptr} + (IDX_W+1)'(k);
        if (pos >= (IDX_W+1)'(N_REQ))
          pos = pos - (IDX_W+1)'(N_REQ);
        if (!win_found && req[pos[IDX_W-1:0]]) begin
          win_found = 1'b1;
          win_idx   = pos[IDX_W-1:0];
        end
      end
    end
  end

  // Sequencer: arbitrate, issue to the multiplier, wait for product or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      tcnt     <= '0;
      done     <= '0;
      result   <= '0;
      sat      <= 1'b0;
      err      <= 1'b0;
      mul_load <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      done <= '0;
      sat  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            idx   <= win_idx;
            mul_a <= a_flat[{win_idx, 4'b0000} +: 16];
            mul_b <= b_flat[{win_idx, 4'b0000} +: 16];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mul_load <= 1'b1;
          tcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            mul_load  <= 1'b0;
            result    <= clamp ? '1 : prod_shifted[OUT_W-1:0];
            sat       <= clamp;
            done[idx] <= 1'b1;
            // Fixed-priority requester 0 never moves the rotation pointer.
            if (!(PRIO0 && idx == '0))
              ptr <= ptr_next;
            state     <= IDLE;
          end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
            mul_load <= 1'b0;
            err      <= 1'b1;
            if (!(PRIO0 && idx == '0))
              ptr <= ptr_next;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bldc_mul_arbiter.sv
// Testbench for bldc_mul_arbiter: transaction-level reference model,
// a behavioural multiplier with variable latency, directed scenarios
// with literal expectations, then a randomized run.
module tb_bldc_mul_arbiter;

  localparam int N       = 3;
  localparam int SHIFT   = 8;
  localparam int OUT_W   = 9;
  localparam int TIMEOUT = 15;
  localparam logic [31:0] MAXV = (32'd1 << OUT_W) - 32'd1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [16*N-1:0]    a_flat, b_flat;
  logic [N-1:0]       done;
  logic [OUT_W-1:0]   result;
  logic               busy, sat, err, mul_load;
  logic [15:0]        mul_a, mul_b;
  logic               mul_valid = 1'b0;
  logic [31:0]        mul_prod  = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bldc_mul_arbiter #(.N_REQ(N), .SHIFT(SHIFT), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .done(done), .result(result), .busy(busy), .sat(sat), .err(err),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_prod(mul_prod)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Multiplier: answers a load after lat cycles (lat=0 stalls forever).
  // Stray strobes are injected only while the arbiter is idle.
  int unsigned lat = 1;
  int unsigned mcnt = 0;
  bit served = 0;
  always @(posedge clk) begin
    mul_valid <= 1'b0;
    if (mul_load !== 1'b1) begin
      served = 0;
      mcnt = 0;
      if (busy !== 1'b1 && $urandom_range(0, 7) == 0) begin
        mul_valid <= 1'b1;
        mul_prod  <= $urandom;
      end
    end else if (!served && lat != 0) begin
      mcnt++;
      if (mcnt >= lat) begin
        mul_valid <= 1'b1;
        mul_prod  <= 32'(mul_a) * 32'(mul_b);
        served = 1;
      end
    end
  end

  // Reference model: one operation at a time, timed from its arbitration cycle.
  int unsigned cyc = 0;
  bit          m_live = 0, m_in_op = 0;
  int unsigned m_t0, m_ptr = 0;
  int          m_idx;
  logic [15:0] m_a, m_b;
  logic [N-1:0]     e_done = '0;
  logic [OUT_W-1:0] e_result = '0;
  bit          e_busy = 0, e_sat = 0, e_err = 0, e_load = 0;
  logic [15:0] e_mul_a = '0, e_mul_b = '0;

  function automatic int pick(input logic [N-1:0] r, input int unsigned p);
`ifdef BLDC_MUL_ARB_PRIORITY0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return int'((p + k) % N);
    return -1;
  endfunction

  function automatic void finish_op();
    m_in_op = 0;
`ifdef BLDC_MUL_ARB_PRIORITY0_EN
    if (m_idx != 0) m_ptr = (m_idx + 1) % N;
`else
    m_ptr = (m_idx + 1) % N;
`endif
  endfunction

  always @(posedge clk) begin
    int w;
    int unsigned age;
    logic [31:0] q;
    cyc++;
    m_live = 1;
    if (rst) begin
      m_in_op = 0; m_ptr = 0;
      e_done = '0; e_result = '0; e_busy = 0; e_sat = 0; e_err = 0;
      e_load = 0; e_mul_a = '0; e_mul_b = '0;
    end else begin
      e_done = '0;
      e_sat  = 0;
      if (!m_in_op) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_in_op = 1; m_t0 = cyc; m_idx = w;
          m_a = a_flat[16*w +: 16];
          m_b = b_flat[16*w +: 16];
          e_mul_a = m_a;
          e_mul_b = m_b;
        end
      end else begin
        age = cyc - m_t0;
        if (age == 1) begin
          e_load = 1;
        end else if (mul_valid) begin
          q = (32'(m_a) * 32'(m_b)) >> SHIFT;
          if (q > MAXV) begin
            e_result = OUT_W'(MAXV);
            e_sat = 1;
          end else begin
            e_result = q[OUT_W-1:0];
          end
          e_done[m_idx] = 1'b1;
          e_load = 0;
          finish_op();
        end else if (age - 1 == TIMEOUT) begin
          e_load = 0;
          e_err = 1;
          finish_op();
        end
      end
      e_busy = m_in_op;
    end
  end

  // Every-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("done",     32'(done),     32'(e_done));
      chk("result",   32'(result),   32'(e_result));
      chk("busy",     32'(busy),     32'(e_busy));
      chk("sat",      32'(sat),      32'(e_sat));
      chk("err",      32'(err),      32'(e_err));
      chk("mul_load", 32'(mul_load), 32'(e_load));
      chk("mul_a",    32'(mul_a),    32'(e_mul_a));
      chk("mul_b",    32'(mul_b),    32'(e_mul_b));
    end
  end

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_flat[16*i +: 16] = a;
    b_flat[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_done(output int who, output int unsigned when_c);
    who = -1;
    when_c = 0;
    for (int c = 0; c < 60 && who < 0; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (done[i]) who = i;
      when_c = cyc;
    end
    if (who < 0) begin
      total++; bad++;
      $display("FAIL done_wait: got no done pulse within 60 cycles expected one");
    end
  endtask

  initial begin
    int who, exp_first, hi;
    int unsigned t, tprev;
    bit saw_done;
    rst = 1; req = '0; a_flat = '0; b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(mul_load), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_mul_a", 32'(mul_a), 0);

    // Single request: 200*128 >> 8 = 100, done at cycle 4.
    rst = 0;
    set_op(0, 16'd200, 16'd128);
    req = 3'b001;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) chk("lat_load_c2", 32'(mul_load), 1);
      if (c == 3) chk("lat_nodone_c3", 32'(done), 0);
    end
    chk("single_done", 32'(done), 32'h1);
    chk("single_result", 32'(result), 32'd100);
    chk("single_sat", 32'(sat), 0);
    req = '0;

    // ptr is now 1: with req=011 requester 1 goes first (300*2>>8 = 2).
    set_op(0, 16'd1, 16'd1);
    set_op(1, 16'd300, 16'd2);
    req = 3'b011;
`ifdef BLDC_MUL_ARB_PRIORITY0_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    wait_done(who, t);
    chk("ptr_first", 32'(who), 32'(exp_first));
    if (who >= 0) req[who] = 1'b0;
    wait_done(who, t);
    chk("ptr_second", 32'(who), 32'(1 - exp_first));
    req = '0;

    // Saturation: 0xFFFF*0xFFFF >> 8 clamps to 511.
    set_op(2, 16'hFFFF, 16'hFFFF);
    req = 3'b100;
    wait_done(who, t);
    chk("sat_who", 32'(who), 2);
    chk("sat_result", 32'(result), 32'd511);
    chk("sat_flag", 32'(sat), 1);
    req = '0;

    // Fairness with all three held from ptr=0.
    do_reset();
    set_op(0, 16'd10, 16'd10);
    set_op(1, 16'd20, 16'd20);
    set_op(2, 16'd30, 16'd30);
    req = 3'b111;
    tprev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done(who, t);
`ifdef BLDC_MUL_ARB_PRIORITY0_EN
      chk("prio_order", 32'(who), 0);
`else
      chk("rr_order", 32'(who), 32'(k % 3));
`endif
      if (k > 0) chk("rr_gap", t - tprev, 4);
      tprev = t;
    end
    req = '0;
    repeat (8) @(posedge clk);

    // Timeout: multiplier stalled, requester 1.
    do_reset();
    lat = 0;
    req = 3'b010;
    hi = 0;
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (mul_load) hi++;
      if (done != '0) saw_done = 1;
      if (hi > 0 && !mul_load && !busy) break;
    end
    chk("to_load_cycles", 32'(hi), TIMEOUT);
    chk("to_err", 32'(err), 1);
    chk("to_nodone", 32'(saw_done), 0);
    req = '0;
    lat = 1;
    set_op(2, 16'd1000, 16'd3);
    req = 3'b100;
    wait_done(who, t);
    chk("to_next_who", 32'(who), 2);
    chk("to_next_result", 32'(result), 32'd11);
    chk("to_err_sticky", 32'(err), 1);
    req = '0;

    // Reset mid-operation, with ptr moved off 0 first.
    req = 3'b001;
    wait_done(who, t);
    req = '0;
    lat = 0;
    req = 3'b010;
    for (int c = 0; c < 20 && !mul_load; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_in_wait", 32'(mul_load), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_load", 32'(mul_load), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_err", 32'(err), 0);
    rst = 0;
    lat = 1;
    req = 3'b111;
    wait_done(who, t);
    chk("mid_first", 32'(who), 0);
    req = '0;

    // Randomized run: operands churn every cycle, requests hold until done.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        set_op(i, 16'($urandom), 16'($urandom));
        if (done[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
      end
      if (c % 16 == 0) lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4);
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 0;
    req = '0;
    lat = 1;
    repeat (30) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

endmodule
